// File: rtl/bram_port_arbiter.sv
// Round-robin sharing of BRAM port A among NREQ requesters, 2-cycle read return.
// Define BRAM_ARB_PARITY_EN to generate write parity and check read parity.
module bram_port_arbiter #(
  parameter int NREQ   = 3,
  parameter int ADDR_W = 10
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req_val,
  input  logic [NREQ-1:0]        req_we,
  input  logic [NREQ*ADDR_W-1:0] req_addr,
  input  logic [NREQ*16-1:0]     req_wdata,
  output logic [NREQ-1:0]        req_rdy,
  output logic [NREQ-1:0]        rsp_val,
  output logic [15:0]            rsp_data,
  output logic                   rsp_perr,
  output logic                   ram_ena,
  output logic                   ram_wea,
  output logic                   ram_ssra,
  output logic [ADDR_W-1:0]      ram_addra,
  output logic [15:0]            ram_dia,
  output logic [1:0]             ram_dipa,
  input  logic [15:0]            ram_doa,
  input  logic [1:0]             ram_dopa
);

  localparam int IDW = $clog2(NREQ);

  logic [IDW-1:0] last_q, last_d;
  logic [IDW-1:0] win_id, cand;
  logic           found;
  logic           s1_vld_q, s1_vld_d;
  logic [IDW-1:0] s1_id_q;
  logic           s2_vld_q;
  logic [IDW-1:0] s2_id_q;
  logic [15:0]    s2_data_q;

  // Cyclic search starting just after the last winner
  always_comb begin
    found  = 1'b0;
    win_id = '0;
    cand   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = IDW'((int'(last_q) + k) % NREQ);
      if (!found && req_val[cand]) begin
        found  = 1'b1;
        win_id = cand;
      end
    end
    if (rst) found = 1'b0;
  end

  assign req_rdy = found ? (NREQ'(1) << win_id) : '0;

  always_comb begin
    ram_ena   = found;
    ram_wea   = 1'b0;
    ram_addra = '0;
    ram_dia   = '0;
    if (found) begin
      ram_wea   = req_we[win_id];
      ram_addra = req_addr[int'(win_id)*ADDR_W +: ADDR_W];
      ram_dia   = req_wdata[int'(win_id)*16 +: 16];
    end
  end

  assign ram_ssra = rst;
  assign last_d   = found ? win_id : last_q;
  assign s1_vld_d = found & ~ram_wea;

  always_ff @(posedge clk) begin
    if (rst) begin
      last_q    <= IDW'(NREQ-1);
      s1_vld_q  <= 1'b0;
      s1_id_q   <= '0;
      s2_vld_q  <= 1'b0;
      s2_id_q   <= '0;
      s2_data_q <= '0;
    end else begin
      last_q   <= last_d;
      s1_vld_q <= s1_vld_d;
      if (found) s1_id_q <= win_id;
      s2_vld_q <= s1_vld_q;
      s2_id_q  <= s1_id_q;
      if (s1_vld_q) s2_data_q <= ram_doa;
    end
  end

  assign rsp_val  = s2_vld_q ? (NREQ'(1) << s2_id_q) : '0;
  assign rsp_data = s2_data_q;

`ifdef BRAM_ARB_PARITY_EN
  logic [1:0] s2_par_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_par_q <= '0;
    end else if (s1_vld_q) begin
      s2_par_q <= ram_dopa;
    end
  end

  assign ram_dipa = {^ram_dia[15:8], ^ram_dia[7:0]};
  assign rsp_perr = s2_vld_q &
    (s2_par_q != {^s2_data_q[15:8], ^s2_data_q[7:0]});
`else
  logic [1:0] unused_dopa;

  assign unused_dopa = ram_dopa;
  assign ram_dipa    = 2'b00;
  assign rsp_perr    = 1'b0;
`endif

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Random and directed stimulus against a round-robin/memory reference model.
// Parity expectations follow BRAM_ARB_PARITY_EN.
module tb_bram_port_arbiter;

  localparam int N  = 3;
  localparam int AW = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst = 1'b1;
  logic [N-1:0]    req_val = '0, req_we = '0;
  logic [N*AW-1:0] req_addr = '0;
  logic [N*16-1:0] req_wdata = '0;
  logic [N-1:0]    req_rdy, rsp_val;
  logic [15:0]     rsp_data;
  logic            rsp_perr;
  logic            ram_ena, ram_wea, ram_ssra;
  logic [AW-1:0]   ram_addra;
  logic [15:0]     ram_dia;
  logic [1:0]      ram_dipa;
  logic [15:0]     ram_doa = '0;
  logic [1:0]      ram_dopa = '0;

  bram_port_arbiter #(.NREQ(N), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst),
    .req_val(req_val), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .req_rdy(req_rdy), .rsp_val(rsp_val),
    .rsp_data(rsp_data), .rsp_perr(rsp_perr),
    .ram_ena(ram_ena), .ram_wea(ram_wea),
    .ram_ssra(ram_ssra), .ram_addra(ram_addra),
    .ram_dia(ram_dia), .ram_dipa(ram_dipa),
    .ram_doa(ram_doa), .ram_dopa(ram_dopa)
  );

  // Read-first RAM port A with optional parity corruption on readout
  bit [15:0] mem  [1024];
  bit [1:0]  pmem [1024];
  bit        bad_par;

  always @(posedge clk) begin
    if (ram_ena) begin
      ram_doa  <= mem[ram_addra];
      ram_dopa <= bad_par ? 2'b00 : pmem[ram_addra];
      if (ram_wea) begin
        mem[ram_addra]  <= ram_dia;
        pmem[ram_addra] <= ram_dipa;
      end
    end
  end

  typedef struct {
    int        due;
    int        id;
    bit [15:0] d;
    bit        pe;
  } rsp_t;

  rsp_t      q[$];
  bit [15:0] smem [1024];
  int        ptr = N-1;
  int        now = 0;
  int        errors = 0;
  int        checks = 0;

  bit        tv [N];
  bit        twe [N];
  bit [9:0]  tad [N];
  bit [15:0] twd [N];
  bit        trst;
  int        gid;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit [1:0] bpar(bit [15:0] d);
    return {^d[15:8], ^d[7:0]};
  endfunction

  task automatic step();
    int       eg;
    int       c;
    rsp_t     e;
    bit [N-1:0] eh;
    bit [1:0] ep;
    @(negedge clk);
    rst = trst;
    for (int i = 0; i < N; i++) begin
      req_val[i]            = tv[i];
      req_we[i]             = twe[i];
      req_addr[i*AW +: AW]  = tad[i];
      req_wdata[i*16 +: 16] = twd[i];
    end
    #1;
    eg = -1;
    if (!trst) begin
      for (int k = 1; k <= N; k++) begin
        c = (ptr + k) % N;
        if (eg < 0 && tv[c]) eg = c;
      end
    end
    eh = '0;
    if (eg >= 0) eh[eg] = 1'b1;
    check("rdy", req_rdy, eh);
    check("ssra", ram_ssra, trst);
    check("ena", ram_ena, eg >= 0);
    if (eg >= 0) begin
`ifdef BRAM_ARB_PARITY_EN
      ep = bpar(twd[eg]);
`else
      ep = 2'b00;
`endif
      check("wea", ram_wea, twe[eg]);
      check("addra", ram_addra, tad[eg]);
      check("dia", ram_dia, twd[eg]);
      check("dipa", ram_dipa, ep);
    end else begin
      check("idle_bus", {ram_wea, ram_addra, ram_dia}, 0);
    end
    if (q.size() > 0 && q[0].due == now) begin
      e = q.pop_front();
      eh = '0;
      eh[e.id] = 1'b1;
      check("rsp_val", rsp_val, eh);
      check("rsp_data", rsp_data, e.d);
      check("rsp_perr", rsp_perr, e.pe);
    end else begin
      check("rsp_idle", rsp_val, 0);
    end
    if (trst) begin
      q.delete();
      ptr = N-1;
    end else if (eg >= 0) begin
      if (twe[eg]) begin
        smem[tad[eg]] = twd[eg];
      end else begin
        e.due = now + 2;
        e.id  = eg;
        e.d   = smem[tad[eg]];
`ifdef BRAM_ARB_PARITY_EN
        e.pe  = bad_par && (bpar(e.d) != 2'b00);
`else
        e.pe  = 1'b0;
`endif
        q.push_back(e);
      end
      ptr = eg;
    end
    gid = eg;
    now++;
  endtask

  task automatic idle();
    for (int i = 0; i < N; i++) tv[i] = 1'b0;
    trst = 1'b0;
  endtask

  task automatic set_req(int i, bit we, bit [9:0] a, bit [15:0] d);
    tv[i]  = 1'b1;
    twe[i] = we;
    tad[i] = a;
    twd[i] = d;
  endtask

  initial begin
    idle();
    trst = 1'b1;
    step();
    step();
    check("rst_data", rsp_data, 0);
    check("rst_perr", rsp_perr, 0);

    // write BEEF then read it back from requester 2
    idle();
    set_req(0, 1'b1, 10'h005, 16'hBEEF);
    step();
    check("t1_gnt", gid, 0);
    idle();
    step();
    step();
    step();
    set_req(2, 1'b0, 10'h005, 16'h0000);
    step();
    idle();
    step();
    step();
    check("t2_val", rsp_val, 3'b100);
    check("t2_data", rsp_data, 16'hBEEF);

    // all three reading after reset
    trst = 1'b1;
    step();
    idle();
    for (int i = 0; i < N; i++) set_req(i, 1'b0, 10'(i + 1), 16'h0);
    for (int i = 0; i < 6; i++) begin
      step();
      check("t3_seq", gid, i % 3);
    end
    idle();
    step();
    step();

    // reset mid-flight discards the read
    set_req(1, 1'b0, 10'h005, 16'h0);
    step();
    check("t4_gnt", gid, 1);
    idle();
    trst = 1'b1;
    step();
    trst = 1'b0;
    step();
    step();
    check("t4_drop", rsp_val, 0);
    for (int i = 0; i < N; i++) set_req(i, 1'b0, 10'h7, 16'h0);
    step();
    check("t4_first", gid, 0);
    idle();
    step();

    // parity generation and corrupted readback
    set_req(0, 1'b1, 10'h020, 16'h0100);
    step();
`ifdef BRAM_ARB_PARITY_EN
    check("t5_dipa", ram_dipa, 2'b10);
`else
    check("t5_dipa", ram_dipa, 2'b00);
`endif
    set_req(0, 1'b0, 10'h020, 16'h0);
    bad_par = 1'b1;
    step();
    bad_par = 1'b0;
    idle();
    step();
    step();
    check("t5_data", rsp_data, 16'h0100);
`ifdef BRAM_ARB_PARITY_EN
    check("t5_perr", rsp_perr, 1'b1);
`else
    check("t5_perr", rsp_perr, 1'b0);
`endif

    // last address, write then immediate read
    set_req(0, 1'b1, 10'h3FF, 16'h1234);
    step();
    idle();
    set_req(1, 1'b0, 10'h3FF, 16'h0);
    step();
    idle();
    step();
    step();
    check("t6_data", rsp_data, 16'h1234);
    check("t6_val", rsp_val, 3'b010);

    // random traffic with held requests and occasional reset
    for (int n = 0; n < 500; n++) begin
      for (int i = 0; i < N; i++) begin
        if (!tv[i] || gid == i) begin
          tv[i]  = $urandom_range(0, 2) != 0;
          twe[i] = $urandom_range(0, 1) != 0;
          tad[i] = ($urandom_range(0, 3) == 0) ? 10'h3FF
                   : 10'($urandom_range(0, 7));
          twd[i] = 16'($urandom);
        end
      end
      trst    = $urandom_range(0, 40) == 0;
      bad_par = $urandom_range(0, 7) == 0;
      step();
    end
    bad_par = 1'b0;
    idle();
    step();
    step();
    step();
    check("drain", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bram_port_arbiter.md
Name: bram_port_arbiter

Overview:
- Round-robin arbiter that shares port A of one 1K x 18 dual-port block RAM (16 data + 2 parity bits) between NREQ requesters.
- Each requester issues single-word reads or writes with a valid/ready handshake.
- The block drives the RAM port-A pins and returns read data to the issuing requester through a registered pipeline with fixed latency.
- Port B is owned elsewhere and is outside this block.

Parameters:
- NREQ, 3, number of requesters (2..4).
- ADDR_W, 10, word address width; matches the 1K x 16 port-A geometry.

Ports:
- clk  in  1  clock; also drives ram_clka.
- rst  in  1  synchronous active-high reset.
- req_val  in  NREQ  per-requester request valid.
- req_we  in  NREQ  1 = write, 0 = read.
- req_addr  in  NREQ*ADDR_W  flattened; requester i occupies bits [i*ADDR_W +: ADDR_W].
- req_wdata  in  NREQ*16  flattened write data; requester i occupies [i*16 +: 16].
- req_rdy  out  NREQ  one-hot grant; the request is accepted when req_val[i] & req_rdy[i].
- rsp_val  out  NREQ  one-hot read-response valid.
- rsp_data  out  16  read data, shared by all requesters; qualified by rsp_val.
- rsp_perr  out  1  read parity error, qualified by rsp_val.
- ram_ena  out  1  RAM port-A enable.
- ram_wea  out  1  RAM port-A write enable.
- ram_ssra  out  1  RAM port-A output set/reset; equals rst.
- ram_addra  out  ADDR_W  RAM port-A address.
- ram_dia  out  16  RAM port-A write data.
- ram_dipa  out  2  RAM port-A write parity.
- ram_doa  in  16  RAM port-A read data; valid 1 cycle after an enabled read edge.
- ram_dopa  in  2  RAM port-A read parity.

Behaviour:
- Grant logic is combinational:
  - req_rdy is a one-hot pick among asserted req_val bits.
  - Search starts at index (last_grant+1) mod NREQ and proceeds cyclically.
  - req_rdy is 0 while rst=1.
  - No request is accepted in the reset cycle.
- last_grant register:
  - Reset value is NREQ-1, so index 0 has first priority after reset.
  - Updates only on a cycle with a grant.
  - With no grant, the pointer holds.
- RAM drive, combinational, in the grant cycle:
  - ram_ena=1.
  - ram_wea = req_we of the winner.
  - ram_addra, ram_dia and ram_dipa come from the winner.
  - With no grant: ram_ena=0, ram_wea=0, and address/data are 0.
- Throughput: one access per cycle maximum; back-to-back grants are allowed, to the same or different requesters.
- Pipeline:
  - Stage 1 registers {valid = grant & ~we, id}.
  - Stage 2 registers {valid, id, ram_doa, ram_dopa} from stage 1.
  - rsp_val = one-hot(id) when stage-2 valid.
  - Read latency is 2 clocks from the accepting edge to rsp_val.
- Responses have no backpressure; requesters must accept rsp_val.
- Writes complete at the accepting edge and produce no response.
- Reset values: rsp_val=0, rsp_data=0, rsp_perr=0, both stage valids=0, last_grant=NREQ-1.
- Reset mid-operation: in-flight reads are discarded and no rsp_val is produced for them.
- Same-address read then write on consecutive cycles: the read returns old data. The RAM handles this with read-first semantics; the arbiter does no forwarding.
- Port-A/port-B collisions are not detected by this block.
- A requester holding req_val without a grant must keep its address, data and we stable. The arbiter does not latch ungranted requests.
- Fairness: any continuously asserted request is granted within NREQ cycles.

Optional Feature:
- Macro: BRAM_ARB_PARITY_EN.
- Defined:
  - ram_dipa[k] = XOR of ram_dia[8k+7:8k], for k = 0..1.
  - On response, rsp_perr = (stage-2 dopa != per-byte XOR of stage-2 doa).
- Not defined:
  - ram_dipa = 2'b00.
  - rsp_perr tied to 0.
  - The dopa capture register is omitted.

Test Plan:
- Reset, then req_val[0]=1, we=1, addr=0x005, wdata=0xBEEF -> req_rdy=001 in that cycle, ram_wea=1, ram_addra=0x005, no rsp_val afterwards.
- Read addr 0x005 from requester 2 -> rsp_val=100 exactly 2 clocks after acceptance, rsp_data=0xBEEF, rsp_perr=0.
- All three requesters hold reads continuously for 6 cycles after reset -> grant sequence 0,1,2,0,1,2, one grant per cycle, each rsp_val one-hot arrives 2 cycles after its grant.
- Requester 1 reads in cycle N and rst is asserted in cycle N+1 -> rsp_val stays 0 through cycle N+3; the first grant after reset goes to index 0.
- BRAM_ARB_PARITY_EN defined: write 0x0100 -> ram_dipa=2'b10. A model returns ram_dopa=2'b00 for the subsequent read -> rsp_perr=1 with rsp_val.
- Requester 0 writes 0x1234 to addr 0x3FF, then requester 1 reads 0x3FF in the next cycle -> rsp_data=0x1234 (last address, no wrap artefacts).
